// File: rtl/seg7_scan_ctrl.sv
// Four-digit seven-segment scan controller: buffers one pending word and commits it only at frame boundaries.
// Optional leading-zero blanking is enabled with the SEG7_LZB_EN macro.
module seg7_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] DATA_IN,
    input  logic [3:0]  DOTS_IN,
    input  logic        DATA_VALID_IN,
    output logic        DATA_READY_OUT,
    output logic [1:0]  SEG_SELECT_OUT,
    output logic [3:0]  BIN_OUT,
    output logic        DOT_OUT,
    output logic        BLANK_OUT,
    output logic        FRAME_OUT
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      disp_data_q, disp_data_d;
    logic [3:0]       disp_dots_q, disp_dots_d;
    logic [15:0]      pend_data_q, pend_data_d;
    logic [3:0]       pend_dots_q, pend_dots_d;
    logic             pend_full_q, pend_full_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       bin_q, bin_d;
    logic             dot_q, dot_d;
    logic             blank_q, blank_d;
    logic             frame_q, frame_d;

    logic             tick;
    logic             frame_bnd;
    logic             accept;
    logic [3:0]       nibble;
    logic             blank;

    always_comb begin
        tick      = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        frame_bnd = tick && (idx_q == 2'd3);
        accept    = DATA_VALID_IN && !pend_full_q;

        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d = tick ? idx_q + 2'd1 : idx_q;

        disp_data_d = disp_data_q;
        disp_dots_d = disp_dots_q;
        pend_data_d = pend_data_q;
        pend_dots_d = pend_dots_q;
        pend_full_d = pend_full_q;

        // A word accepted on the boundary cycle is not bypassed; it waits a full frame.
        if (frame_bnd && pend_full_q) begin
            disp_data_d = pend_data_q;
            disp_dots_d = pend_dots_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_data_d = DATA_IN;
            pend_dots_d = DOTS_IN;
            pend_full_d = 1'b1;
        end

        nibble = disp_data_q[{idx_q, 2'b00} +: 4];
`ifdef SEG7_LZB_EN
        case (idx_q)
            2'd3:    blank = (disp_data_q[15:12] == 4'h0);
            2'd2:    blank = (disp_data_q[15:8] == 8'h00);
            2'd1:    blank = (disp_data_q[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif

        sel_d   = idx_q;
        bin_d   = blank ? 4'h0 : nibble;
        dot_d   = disp_dots_q[idx_q];
        blank_d = blank;
        frame_d = frame_bnd;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            disp_data_q <= 16'h0000;
            disp_dots_q <= 4'h0;
            pend_data_q <= 16'h0000;
            pend_dots_q <= 4'h0;
            pend_full_q <= 1'b0;
            sel_q       <= 2'd0;
            bin_q       <= 4'h0;
            dot_q       <= 1'b0;
            blank_q     <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            disp_data_q <= disp_data_d;
            disp_dots_q <= disp_dots_d;
            pend_data_q <= pend_data_d;
            pend_dots_q <= pend_dots_d;
            pend_full_q <= pend_full_d;
            sel_q       <= sel_d;
            bin_q       <= bin_d;
            dot_q       <= dot_d;
            blank_q     <= blank_d;
            frame_q     <= frame_d;
        end
    end

    assign DATA_READY_OUT = ~pend_full_q;
    assign SEG_SELECT_OUT = sel_q;
    assign BIN_OUT        = bin_q;
    assign DOT_OUT        = dot_q;
    assign BLANK_OUT      = blank_q;
    assign FRAME_OUT      = frame_q;

endmodule
